// File: rtl/qnt_expand.sv
// qnt_expand: maps narrow signed quantizer codes back to wide signed
// reconstruction levels, and optionally counts extreme (saturation) codes
// over a window of accepted samples.
//
// Optional feature macro: QNT_EXPAND_STAT_EN
//   defined   -> window/edge counters built, stat_out/stat_valid live
//   undefined -> stat_out = 0, stat_valid = 0, win_len ignored
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   WE         input sample strobe
//   in         signed quantizer code   [IN_WIDTH]
//   valid      out strobe (WE delayed by two cycles)
//   out        signed reconstruction   [OUT_WIDTH]
//   win_len    window length in accepted samples, 0 = statistics off
//   stat_out   extreme-code count of the last completed window
//   stat_valid one-cycle pulse when stat_out updates
module qnt_expand #(
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned OUT_WIDTH   = 6,
  parameter int unsigned SYMMETRICAL = 0,
  parameter int unsigned WIN_WIDTH   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WE,
  input  logic [IN_WIDTH-1:0]  in,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] out,
  input  logic [WIN_WIDTH-1:0] win_len,
  output logic [WIN_WIDTH-1:0] stat_out,
  output logic                 stat_valid
);

  localparam int unsigned SHIFT = OUT_WIDTH - IN_WIDTH;

  logic                        r_we1;
  logic [IN_WIDTH-1:0]         r_code1;
  logic                        r_valid;
  logic [OUT_WIDTH-1:0]        r_out;
  logic signed [OUT_WIDTH-1:0] w_ext;
  logic [OUT_WIDTH-1:0]        w_map;

  // Sign-extend the stage-1 code to output width before shifting.
  assign w_ext = OUT_WIDTH'($signed(r_code1));

  // Reconstruction level: c << S, or (2c+1) << (S-1) for mid-rise levels.
  generate
    if (SYMMETRICAL != 0) begin : g_sym
      assign w_map = ((w_ext <<< 1) | OUT_WIDTH'(1)) <<< (SHIFT - 1);
    end else begin : g_twos
      assign w_map = w_ext <<< SHIFT;
    end
  endgenerate

  // Two-stage data pipeline; out holds while valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we1   <= 1'b0;
      r_code1 <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_we1   <= WE;
      if (WE) r_code1 <= in;
      r_valid <= r_we1;
      if (r_we1) r_out <= w_map;
    end
  end

  assign valid = r_valid;
  assign out   = r_out;

`ifdef QNT_EXPAND_STAT_EN
  logic                 w_extreme;
  logic [WIN_WIDTH:0]   w_cnt_inc;
  logic [WIN_WIDTH-1:0] w_edge_inc;
  logic                 w_close;
  logic [WIN_WIDTH-1:0] r_cnt;
  logic [WIN_WIDTH-1:0] r_edge;
  logic [WIN_WIDTH-1:0] r_stat_out;
  logic                 r_stat_valid;

  // Extreme codes are the most positive and most negative quantizer values.
  assign w_extreme  = (in == {1'b0, {(IN_WIDTH-1){1'b1}}}) ||
                      (in == {1'b1, {(IN_WIDTH-1){1'b0}}});
  assign w_cnt_inc  = {1'b0, r_cnt} + (WIN_WIDTH+1)'(1);
  assign w_edge_inc = r_edge + WIN_WIDTH'(w_extreme);
  // Compared live with >= so a shrunk win_len closes on the next sample.
  assign w_close    = (w_cnt_inc >= {1'b0, win_len});

  // Window statistics: counters only advance on accepted samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_edge       <= '0;
      r_stat_out   <= '0;
      r_stat_valid <= 1'b0;
    end else begin
      r_stat_valid <= 1'b0;
      if (win_len == '0) begin
        r_cnt  <= '0;
        r_edge <= '0;
      end else if (WE) begin
        if (w_close) begin
          r_stat_out   <= w_edge_inc;
          r_stat_valid <= 1'b1;
          r_cnt        <= '0;
          r_edge       <= '0;
        end else begin
          r_cnt  <= w_cnt_inc[WIN_WIDTH-1:0];
          r_edge <= w_edge_inc;
        end
      end
    end
  end

  assign stat_out   = r_stat_out;
  assign stat_valid = r_stat_valid;
`else
  logic w_unused_win;

  assign w_unused_win = ^win_len;
  assign stat_out     = '0;
  assign stat_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_qnt_expand.sv
// Directed bench for qnt_expand: two instances (two's-complement and
// symmetric levels) share stimulus; statistics are checked on the first.
module tb_qnt_expand;

  localparam int unsigned IW = 4;
  localparam int unsigned OW = 6;
  localparam int unsigned WW = 10;
`ifdef QNT_EXPAND_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [IW-1:0] in_c;
  logic [WW-1:0] win_len;
  logic          valid0, valid1, sv0, sv1;
  logic [OW-1:0] out0, out1;
  logic [WW-1:0] so0, so1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference pipeline state
  bit m_we1, m_v;
  int m_c1, m_o0, m_o1;
  int exp_so;

  always #5 clk = ~clk;

  qnt_expand #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SYMMETRICAL(0), .WIN_WIDTH(WW)) u_sym0 (
    .clk(clk), .reset(reset), .WE(we), .in(in_c), .valid(valid0), .out(out0),
    .win_len(win_len), .stat_out(so0), .stat_valid(sv0)
  );

  qnt_expand #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SYMMETRICAL(1), .WIN_WIDTH(WW)) u_sym1 (
    .clk(clk), .reset(reset), .WE(we), .in(in_c), .valid(valid1), .out(out1),
    .win_len(win_len), .stat_out(so1), .stat_valid(sv1)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the reference pipeline, then check both data paths.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_we1 = 1'b0; m_c1 = 0; m_v = 1'b0; m_o0 = 0; m_o1 = 0;
    end else begin
      m_v = m_we1;
      if (m_we1) begin
        m_o0 = m_c1 * 4;
        m_o1 = m_c1 * 4 + 2;
      end
      m_we1 = we;
      if (we) m_c1 = int'($signed(in_c));
    end
    #1;
    chk("valid0", 32'(valid0), 32'(m_v));
    chk("out0",   32'($signed(out0)), m_o0);
    chk("valid1", 32'(valid1), 32'(m_v));
    chk("out1",   32'($signed(out1)), m_o1);
  endtask

  task automatic stat(input bit pulse, input int val);
    if (STAT && pulse) exp_so = val;
    chk("stat_valid", 32'(sv0), 32'(STAT && pulse));
    chk("stat_out",   32'(so0), exp_so);
  endtask

  // Single WE pulse with hand-computed levels for both mappings.
  task automatic pulse(input int c, input int e0, input int e1);
    we = 1'b1; in_c = IW'(c);
    tick();
    we = 1'b0;
    chk("pulse_early_valid", 32'(valid0), 0);
    tick();
    chk("pulse_valid0", 32'(valid0), 1);
    chk("pulse_out0",   32'($signed(out0)), e0);
    chk("pulse_valid1", 32'(valid1), 1);
    chk("pulse_out1",   32'($signed(out1)), e1);
    tick();
    chk("pulse_drop_valid", 32'(valid0), 0);
    chk("pulse_hold_out0",  32'($signed(out0)), e0);
    stat(1'b0, 0);
  endtask

  initial begin
    exp_so = 0;
    reset = 1'b1; we = 1'b0; in_c = '0; win_len = '0;
    tick();
    tick();
    chk("rst_valid",      32'(valid0), 0);
    chk("rst_out",        32'($signed(out0)), 0);
    chk("rst_stat_out",   32'(so0), 0);
    chk("rst_stat_valid", 32'(sv0), 0);
    reset = 1'b0;

    // Mapping of boundary and mid codes
    pulse(7, 28, 30);
    pulse(-8, -32, -30);
    pulse(-1, -4, -2);
    pulse(0, 0, 2);

    // Ramp, every cycle, 16-sample windows: 7 and -8 per window
    win_len = WW'(16);
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; in_c = IW'(i);
      tick();
      stat((i % 16) == 15, 2);
    end

    // Same ramp, 8-sample windows: one extreme per half
    win_len = WW'(8);
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; in_c = IW'(i);
      tick();
      stat((i % 8) == 7, 1);
    end

    // WE every other cycle, all extremes, 4-sample windows
    win_len = WW'(4);
    for (int k = 0; k < 16; k++) begin
      we = ((k % 2) == 0); in_c = IW'(7);
      tick();
      if (k >= 1) chk("alt_valid", 32'(valid0), 32'((k % 2) == 1));
      stat(k == 6 || k == 14, 4);
    end
    we = 1'b0;
    tick();
    tick();

    // Reset part-way through a 16-sample window
    win_len = WW'(16);
    for (int j = 0; j < 5; j++) begin
      we = 1'b1; in_c = IW'(7);
      tick();
      stat(1'b0, 0);
    end
    we = 1'b0; reset = 1'b1;
    tick();
    exp_so = 0;
    chk("mid_rst_valid",      32'(valid0), 0);
    chk("mid_rst_out",        32'($signed(out0)), 0);
    chk("mid_rst_stat_out",   32'(so0), 0);
    chk("mid_rst_stat_valid", 32'(sv0), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_valid", 32'(valid0), 0);
    stat(1'b0, 0);

    // Fresh window of 16 extremes after reset
    for (int j = 0; j < 16; j++) begin
      we = 1'b1; in_c = IW'(7);
      tick();
      stat(j == 15, 16);
    end
    we = 1'b0;
    tick();
    stat(1'b0, 0);
    tick();
    stat(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
